// File: rtl/noc_pkg.sv
//------------------------------------------------------------------------------
// Module      : noc_pkg
// Description : Shared NoC constants (packet/flit geometry, address field
//               positions) and the transmit serializer state type.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package noc_pkg;

  localparam int unsigned PACKET_SIZE      = 32;
  localparam int unsigned FLIT_SIZE        = 4;
  localparam int unsigned FLITS_PER_PACKET = PACKET_SIZE / FLIT_SIZE;
  localparam int unsigned FLIT_CNT_WIDTH   = $clog2(FLITS_PER_PACKET);

  // Destination address fields inside a spike packet
  localparam int unsigned X_MSB = 31;
  localparam int unsigned X_LSB = 24;
  localparam int unsigned Y_MSB = 23;
  localparam int unsigned Y_LSB = 16;

  // Serializer states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

endpackage : noc_pkg

`default_nettype wire

// File: rtl/packet_fifo.sv
//------------------------------------------------------------------------------
// Module      : packet_fifo
// Description : Single-clock show-ahead FIFO. A push into a full FIFO is
//               accepted when a pop happens on the same edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module packet_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  // Flags are decoded from the registered count only
  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign dout = r_mem[r_rd_ptr];

  // Storage array; write-only on accepted pushes, no reset needed
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^N
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule : packet_fifo

`default_nettype wire

// File: rtl/spike_packetizer.sv
//------------------------------------------------------------------------------
// Module      : spike_packetizer
// Description : Neuron-to-router transmit path. Buffers strobed spike packets
//               in a packet FIFO and serializes them MSB-flit-first onto the
//               router local port under local_full back-pressure. Packets
//               arriving at a full FIFO are dropped and counted (saturating).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spike_packetizer #(
  parameter int unsigned PACKET_SIZE     = noc_pkg::PACKET_SIZE,
  parameter int unsigned FLIT_SIZE       = noc_pkg::FLIT_SIZE,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned FIFO_ADDR_WIDTH = 2,
  parameter int unsigned DROP_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PACKET_SIZE-1:0]    packet_in,
  input  logic                      packet_valid,
  input  logic                      local_full,
  output logic [FLIT_SIZE-1:0]      flit_out,
  output logic                      flit_write_en,
  output logic                      busy,
  output logic                      fifo_full,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  import noc_pkg::*;

  localparam int unsigned FLITS_PER_PKT = PACKET_SIZE / FLIT_SIZE;
  localparam int unsigned CNT_W         = $clog2(FLITS_PER_PKT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLITS_PER_PKT - 1);

  tx_state_t               r_state;
  tx_state_t               w_state_next;
  logic [PACKET_SIZE-1:0]  r_shift;
  logic [CNT_W-1:0]        r_cnt;
  logic [DROP_CNT_WIDTH-1:0] r_drop;

  logic                    w_pop;
  logic                    w_flit_we;
  logic                    w_last_flit;
  logic                    w_drop;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;
  logic [PACKET_SIZE-1:0]  w_fifo_dout;

  // Packet buffer between the neuron strobe and the serializer
  packet_fifo #(
    .WIDTH      (PACKET_SIZE),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (packet_valid),
    .pop   (w_pop),
    .din   (packet_in),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  assign w_flit_we   = (r_state == ST_SEND) && !local_full;
  assign w_last_flit = w_flit_we && (r_cnt == LAST_CNT);
  // A full FIFO still accepts when the serializer pops on the same edge
  assign w_drop      = packet_valid && w_fifo_full && !w_pop;

  // Serializer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and pop decision; chained pop on the last flit avoids a bubble
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_last_flit) begin
          if (!w_fifo_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Shift register and flit counter; the final shift leaves the register zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_pop) begin
      r_shift <= w_fifo_dout;
      r_cnt   <= '0;
    end else if (w_flit_we) begin
      r_shift <= r_shift << FLIT_SIZE;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Saturating count of packets lost to overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_drop && !(&r_drop)) begin
      r_drop <= r_drop + DROP_CNT_WIDTH'(1);
    end
  end

  assign flit_out      = r_shift[PACKET_SIZE-1 -: FLIT_SIZE];
  assign flit_write_en = w_flit_we;
  assign busy          = (r_state == ST_SEND) || !w_fifo_empty;
  assign fifo_full     = w_fifo_full;
  assign drop_count    = r_drop;

endmodule : spike_packetizer

`default_nettype wire

// File: tb/tb_spike_packetizer.sv
//------------------------------------------------------------------------------
// Module      : tb_spike_packetizer
// Description : Self-checking bench for spike_packetizer with a flit
//               scoreboard fed at stimulus time and drained by a monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spike_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] packet_in;
  logic        packet_valid;
  logic        local_full;
  logic [3:0]  flit_out;
  logic        flit_write_en;
  logic        busy;
  logic        fifo_full;
  logic [7:0]  drop_count;

  spike_packetizer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .packet_in     (packet_in),
    .packet_valid  (packet_valid),
    .local_full    (local_full),
    .flit_out      (flit_out),
    .flit_write_en (flit_write_en),
    .busy          (busy),
    .fifo_full     (fifo_full),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int first_wr = -1;
  int last_wr  = -1;

  // Monitor: every written flit must match the scoreboard head
  always @(negedge clk) begin
    logic [3:0] exp;
    if (rst_n && flit_write_en) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr  = cyc;
      wr_count = wr_count + 1;
      n_checks = n_checks + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL flit_unexpected: got %h, expected no write", flit_out);
      end else begin
        exp = sb.pop_front();
        if (flit_out !== exp) begin
          n_fail = n_fail + 1;
          $display("FAIL flit_value: got %h, expected %h (write #%0d)", flit_out, exp, wr_count);
        end
      end
    end
  end

  task automatic push_pkt(input logic [31:0] p);
    for (int i = 7; i >= 0; i--) sb.push_back(p[i*4 +: 4]);
  endtask

  // Drive one-cycle strobe; entered and left at posedge+1
  task automatic strobe(input logic [31:0] p);
    packet_in    = p;
    packet_valid = 1'b1;
    @(posedge clk);
    #1;
    packet_valid = 1'b0;
  endtask

  task automatic clear_stats();
    wr_count = 0;
    first_wr = -1;
    last_wr  = -1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; packet_valid = 1'b0; packet_in = '0; local_full = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (flit_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, expected 0", flit_write_en); end
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (fifo_full !== 1'b0)     begin n_fail++; $display("FAIL reset_full: got %b, expected 0", fifo_full); end
    if (drop_count !== 8'd0)    begin n_fail++; $display("FAIL reset_drop: got %0d, expected 0", drop_count); end
    if (flit_out !== 4'h0)      begin n_fail++; $display("FAIL reset_flit: got %h, expected 0", flit_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_single();
    bit ok; int n;
    clear_stats();
    push_pkt(32'h1234ABCD);
    strobe(32'h1234ABCD);
    n = cyc;
    wait_drain(40, ok);
    n_checks += 6;
    if (!ok)                  begin n_fail++; $display("FAIL single_timeout: drain not reached, %0d flits left", sb.size()); end
    if (first_wr !== n + 1)   begin n_fail++; $display("FAIL single_latency: first write cycle %0d, expected %0d", first_wr, n + 1); end
    if (wr_count !== 8)       begin n_fail++; $display("FAIL single_count: got %0d writes, expected 8", wr_count); end
    if (last_wr - first_wr !== 7) begin n_fail++; $display("FAIL single_span: got %0d, expected 7", last_wr - first_wr); end
    if (flit_out !== 4'h0)    begin n_fail++; $display("FAIL single_idle_flit: got %h, expected 0", flit_out); end
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL single_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok; bit found;
    clear_stats();
    push_pkt(32'h1234ABCD);
    strobe(32'h1234ABCD);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wr_count == 3) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL bp_third_flit: got %0d writes, expected 3", wr_count); end
    local_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (flit_write_en !== 1'b0) begin n_fail++; $display("FAIL bp_hold_we: got %b, expected 0 (cycle %0d)", flit_write_en, i); end
      if (flit_out !== 4'h4)      begin n_fail++; $display("FAIL bp_hold_flit: got %h, expected 4 (cycle %0d)", flit_out, i); end
    end
    @(posedge clk); #1;
    local_full = 1'b0;
    wait_drain(40, ok);
    n_checks += 3;
    if (!ok)                       begin n_fail++; $display("FAIL bp_timeout: %0d flits left", sb.size()); end
    if (wr_count !== 8)            begin n_fail++; $display("FAIL bp_count: got %0d, expected 8", wr_count); end
    if (last_wr - first_wr !== 10) begin n_fail++; $display("FAIL bp_span: got %0d cycles, expected 11", last_wr - first_wr + 1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_stats();
    push_pkt(32'h11111111);
    push_pkt(32'h22222222);
    strobe(32'h11111111);
    strobe(32'h22222222);
    wait_drain(60, ok);
    n_checks += 3;
    if (!ok)                       begin n_fail++; $display("FAIL b2b_timeout: %0d flits left", sb.size()); end
    if (wr_count !== 16)           begin n_fail++; $display("FAIL b2b_count: got %0d, expected 16", wr_count); end
    if (last_wr - first_wr !== 15) begin n_fail++; $display("FAIL b2b_gap: span %0d, expected 16", last_wr - first_wr + 1); end
  endtask

  task automatic test_overflow();
    bit ok; logic [31:0] p;
    clear_stats();
    local_full = 1'b1;
    // One packet sits in the shift register, four fill the FIFO, the sixth drops
    for (int i = 0; i < 6; i++) begin
      p = 32'h01234567 + 32'(i) * 32'h11111111;
      if (i < 5) push_pkt(p);
      strobe(p);
    end
    @(negedge clk);
    n_checks += 4;
    if (fifo_full !== 1'b1)     begin n_fail++; $display("FAIL ovf_full: got %b, expected 1", fifo_full); end
    if (drop_count !== 8'd1)    begin n_fail++; $display("FAIL ovf_drop: got %0d, expected 1", drop_count); end
    if (flit_write_en !== 1'b0) begin n_fail++; $display("FAIL ovf_we: got %b, expected 0", flit_write_en); end
    if (busy !== 1'b1)          begin n_fail++; $display("FAIL ovf_busy: got %b, expected 1", busy); end
    @(posedge clk); #1;
    local_full = 1'b0;
    wait_drain(100, ok);
    n_checks += 3;
    if (!ok)                       begin n_fail++; $display("FAIL ovf_timeout: %0d flits left", sb.size()); end
    if (wr_count !== 40)           begin n_fail++; $display("FAIL ovf_count: got %0d, expected 40", wr_count); end
    if (last_wr - first_wr !== 39) begin n_fail++; $display("FAIL ovf_span: got %0d, expected 40", last_wr - first_wr + 1); end
  endtask

  task automatic test_saturate();
    bit ok; logic [31:0] p;
    clear_stats();
    local_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p = 32'hA0B0C0D0 + 32'(i);
      push_pkt(p);
      strobe(p);
    end
    for (int i = 0; i < 300; i++) strobe(32'hFFFFFFFF);
    @(negedge clk);
    n_checks += 2;
    if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_drop: got %0d, expected 255", drop_count); end
    if (fifo_full !== 1'b1)    begin n_fail++; $display("FAIL sat_full: got %b, expected 1", fifo_full); end
    @(posedge clk); #1;
    strobe(32'hFFFFFFFF);
    @(negedge clk);
    n_checks++;
    if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d, expected 255", drop_count); end
    @(posedge clk); #1;
    local_full = 1'b0;
    wait_drain(100, ok);
    n_checks += 2;
    if (!ok)             begin n_fail++; $display("FAIL sat_timeout: %0d flits left", sb.size()); end
    if (wr_count !== 40) begin n_fail++; $display("FAIL sat_count: got %0d, expected 40", wr_count); end
  endtask

  task automatic test_reset_mid();
    bit found;
    clear_stats();
    sb.push_back(4'hD);
    sb.push_back(4'hE);
    sb.push_back(4'hA);
    strobe(32'hDEADBEEF);
    strobe(32'h55555555);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wr_count == 3) begin found = 1'b1; break; end
    end
    n_checks += 2;
    if (!found)        begin n_fail++; $display("FAIL rst_mid_third: got %0d writes, expected 3", wr_count); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_pre: got %b, expected 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (flit_write_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we: got %b, expected 0", flit_write_en); end
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
    if (fifo_full !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_full: got %b, expected 0", fifo_full); end
    if (drop_count !== 8'd0)    begin n_fail++; $display("FAIL rst_mid_drop: got %0d, expected 0", drop_count); end
    if (flit_out !== 4'h0)      begin n_fail++; $display("FAIL rst_mid_flit: got %h, expected 0", flit_out); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks += 3;
    if (wr_count !== 3)  begin n_fail++; $display("FAIL rst_mid_resume: got %0d writes, expected 3", wr_count); end
    if (busy !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_idle: got %b, expected 0", busy); end
    if (sb.size() !== 0) begin n_fail++; $display("FAIL rst_mid_sb: got %0d left, expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_spike_packetizer

`default_nettype wire

// File: doc/spike_packetizer.md
Name: spike_packetizer

Overview:
Neuron-to-router transmit path of a neuron cell, the counterpart of the router-to-neuron flit receiver interface. Accepts whole spike packets from the neuron on a one-cycle strobe and buffers them in a small packet FIFO. Serializes each packet MSB-nibble-first into flits on the router's local input port, honouring the router's local full back-pressure. Counts packets dropped on FIFO overflow.

Parameters:
PACKET_SIZE, 32, spike packet width in bits; must be a multiple of FLIT_SIZE.
FLIT_SIZE, 4, flit width in bits.
FIFO_DEPTH, 4, packet FIFO depth in packets; power of two, at least 2.
FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH).
DROP_CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
clk  in  1  neuron clock; all state is updated on the rising edge.
rst_n  in  1  asynchronous active-low reset.
packet_in  in  PACKET_SIZE  spike packet from the neuron; bits [31:24] x dest, [23:16] y dest, rest payload (opaque here).
packet_valid  in  1  one-cycle strobe: packet_in is valid this cycle.
local_full  in  1  router local input buffer full; no flit may be written while high.
flit_out  out  FLIT_SIZE  current flit to the router local input.
flit_write_en  out  1  flit_out is written into the router at this rising edge.
busy  out  1  serializer holds a packet (SEND state) or FIFO is non-empty.
fifo_full  out  1  packet FIFO holds FIFO_DEPTH packets.
drop_count  out  DROP_CNT_WIDTH  packets discarded due to overflow; saturating.

Behaviour:
- Reset (async, rst_n low): FIFO emptied, state IDLE, shift register 0, flit counter 0, drop_count 0. Outputs read flit_out=0, flit_write_en=0, busy=0, fifo_full=0. Any partially sent packet is discarded and never resumed.
- FLITS_PER_PACKET = PACKET_SIZE/FLIT_SIZE (8 by default). The flit counter is FLIT_CNT_WIDTH = log2(FLITS_PER_PACKET) bits wide.
- Push: at an edge with packet_valid=1, packet_in is written to the FIFO if count<FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the packet is dropped and drop_count increments, holding at all-ones.
- FSM states: IDLE, SEND.
  - IDLE: if FIFO is non-empty at an edge, pop the head into the shift register, clear the flit counter, go to SEND.
  - A packet pushed into an empty FIFO is therefore popped one edge later.
- SEND, outputs:
  - flit_out = shift register MSB FLIT_SIZE bits, driven from a register.
  - flit_write_en = (state==SEND) && !local_full, combinational.
- SEND, on each edge with flit_write_en=1: shift left by FLIT_SIZE and increment the counter.
- SEND, last flit (counter==FLITS_PER_PACKET-1 and flit_write_en=1):
  - If the FIFO is non-empty, pop the next packet at the same edge, clear the counter and stay in SEND, so there is no bubble between packets.
  - Otherwise go to IDLE.
- Back-pressure: while local_full=1, flit_write_en=0 and shift register, counter and flit_out hold. Resume on the first cycle local_full=0. There is no timeout.
- Latency: packet_valid at edge N into an idle, empty block gives the first flit_write_en in the cycle following edge N+1, i.e. written at edge N+2. With no back-pressure the packet occupies 8 consecutive cycles.
- Simultaneous push and pop with FIFO full: accepted, count unchanged, no drop.
- Simultaneous push and pop with FIFO empty in IDLE: the pushed packet is not bypassed; it is popped at the next edge.
- flit_out in IDLE: holds 0 (shift register is zeroed by the final shift).
- fifo_full and busy are registered or decoded from registered state; they carry no combinational path from inputs.

Decomposition:
- Shared package noc_pkg holds:
  - PACKET_SIZE, FLIT_SIZE, FLITS_PER_PACKET, FLIT_CNT_WIDTH.
  - The address field positions (X_MSB/X_LSB, Y_MSB/Y_LSB) also used by the receive interface.
  - The FSM state typedef.
- One sub-module, packet_fifo: synchronous single-clock FIFO parameterized by width and depth.
  - Ports: push, pop, din, dout (head, show-ahead), empty, full, same-edge push/pop support.
- The serializer FSM stays in spike_packetizer.

Test Plan:
- Single packet 0x1234ABCD strobed at edge N, local_full=0 -> flit_write_en high edges N+2..N+9 with flits 1,2,3,4,A,B,C,D; then busy=0, flit_out=0.
- Same packet, local_full=1 for 3 cycles right after flit 3 is written -> flit_write_en=0 and flit_out=4 held for those 3 cycles; remaining flits 4,A,B,C,D follow consecutively; total 11 cycles.
- Two packets 0x11111111 and 0x22222222 strobed on consecutive edges -> 16 consecutive write cycles: eight 1s then eight 2s, no gap.
- local_full held 1, six packets strobed on consecutive edges -> first packet loaded into shift register (IDLE pops it); FIFO gets 4 more, fifo_full=1, drop_count=1. Releasing local_full -> exactly 5 packets emitted, in order.
- With FIFO full and local_full=1, strobe 300 packets -> drop_count saturates at 255 and stays there.
- Reset asserted after 3 flits of 0xDEADBEEF with a second packet queued -> flit_write_en, busy, fifo_full, drop_count go 0 immediately (asynchronously). After release with no new input, no flits are emitted.
